// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with freeze, flush/hazard bubble insertion and a
// saturating bubble counter for performance monitoring.
module id_exe_stage_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        flush,
  input  logic        hazard,
  input  logic        valid_in,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        b_in,
  input  logic        s_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic        imm_in,
  input  logic [11:0] shift_operand_in,
  input  logic [23:0] signed_imm_24_in,
  input  logic [3:0]  dest_in,
  input  logic [3:0]  src1_in,
  input  logic [3:0]  src2_in,
  input  logic [3:0]  sr_in,
  output logic        valid_out,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic        b,
  output logic        s,
  output logic [3:0]  exe_cmd,
  output logic [31:0] pc,
  output logic [31:0] val_rn,
  output logic [31:0] val_rm,
  output logic        imm,
  output logic [11:0] shift_operand,
  output logic [23:0] signed_imm_24,
  output logic [3:0]  dest,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic [3:0]  sr,
  output logic [15:0] bubble_count
);

  typedef struct packed {
    logic        valid;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        b;
    logic        s;
    logic [3:0]  exe_cmd;
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  sr;
  } entry_t;

  entry_t      entry_d, entry_q;
  entry_t      entry_in;
  logic [15:0] bubble_count_d, bubble_count_q;
  logic        kill;
  logic        bubble;

  assign kill   = flush | hazard;
  assign bubble = kill | ~valid_in;

  always_comb begin
    entry_in               = '0;
    entry_in.valid         = 1'b1;
    entry_in.wb_en         = wb_en_in;
    entry_in.mem_r_en      = mem_r_en_in;
    entry_in.mem_w_en      = mem_w_en_in;
    entry_in.b             = b_in;
    entry_in.s             = s_in;
    entry_in.exe_cmd       = exe_cmd_in;
    entry_in.pc            = pc_in;
    entry_in.val_rn        = val_rn_in;
    entry_in.val_rm        = val_rm_in;
    entry_in.imm           = imm_in;
    entry_in.shift_operand = shift_operand_in;
    entry_in.signed_imm_24 = signed_imm_24_in;
    entry_in.dest          = dest_in;
    entry_in.src1          = src1_in;
    entry_in.src2          = src2_in;
    entry_in.sr            = sr_in;
  end

  always_comb begin
    entry_d        = entry_q;
    bubble_count_d = bubble_count_q;
    if (!freeze) begin
      if (bubble) begin
        // Whole entry cleared so a bubble can never write back, branch or set flags.
        entry_d = '0;
        if (kill && (bubble_count_q != 16'hFFFF)) begin
          bubble_count_d = bubble_count_q + 16'd1;
        end
      end else begin
        entry_d = entry_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q        <= '0;
      bubble_count_q <= '0;
    end else begin
      entry_q        <= entry_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign valid_out     = entry_q.valid;
  assign wb_en         = entry_q.wb_en;
  assign mem_r_en      = entry_q.mem_r_en;
  assign mem_w_en      = entry_q.mem_w_en;
  assign b             = entry_q.b;
  assign s             = entry_q.s;
  assign exe_cmd       = entry_q.exe_cmd;
  assign pc            = entry_q.pc;
  assign val_rn        = entry_q.val_rn;
  assign val_rm        = entry_q.val_rm;
  assign imm           = entry_q.imm;
  assign shift_operand = entry_q.shift_operand;
  assign signed_imm_24 = entry_q.signed_imm_24;
  assign dest          = entry_q.dest;
  assign src1          = entry_q.src1;
  assign src2          = entry_q.src2;
  assign sr            = entry_q.sr;
  assign bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Randomized and directed bench for id_exe_stage_reg against a whole-entry
// behavioural model (hold / clear / copy, plus a clamped bubble tally).
module tb_id_exe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        freeze = 1'b0, flush = 1'b0, hazard = 1'b0, valid_in = 1'b0;
  logic        wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0, b_in = 1'b0;
  logic        s_in = 1'b0, imm_in = 1'b0;
  logic [3:0]  exe_cmd_in = '0, dest_in = '0, src1_in = '0, src2_in = '0, sr_in = '0;
  logic [31:0] pc_in = '0, val_rn_in = '0, val_rm_in = '0;
  logic [11:0] shift_operand_in = '0;
  logic [23:0] signed_imm_24_in = '0;

  logic        valid_out, wb_en, mem_r_en, mem_w_en, b, s, imm;
  logic [3:0]  exe_cmd, dest, src1, src2, sr;
  logic [31:0] pc, val_rn, val_rm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [15:0] bubble_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: the full output word and the bubble tally.
  logic [158:0] exp_vec = '0;
  int           exp_cnt = 0;

  logic [158:0] obs;
  logic [158:0] in_vec;
  assign obs = {valid_out, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd, pc, val_rn, val_rm, imm,
                shift_operand, signed_imm_24, dest, src1, src2, sr};
  assign in_vec = {1'b1, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in, pc_in,
                   val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm_24_in, dest_in,
                   src1_in, src2_in, sr_in};

  id_exe_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .hazard(hazard),
    .valid_in(valid_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .sr_in(sr_in),
    .valid_out(valid_out), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .b(b), .s(s), .exe_cmd(exe_cmd), .pc(pc), .val_rn(val_rn), .val_rm(val_rm), .imm(imm),
    .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .dest(dest),
    .src1(src1), .src2(src2), .sr(sr), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic rand_fields();
    wb_en_in         = 1'($urandom);
    mem_r_en_in      = 1'($urandom);
    mem_w_en_in      = 1'($urandom);
    b_in             = 1'($urandom);
    s_in             = 1'($urandom);
    imm_in           = 1'($urandom);
    exe_cmd_in       = 4'($urandom);
    pc_in            = $urandom;
    val_rn_in        = $urandom;
    val_rm_in        = $urandom;
    shift_operand_in = 12'($urandom);
    signed_imm_24_in = 24'($urandom);
    dest_in          = 4'($urandom);
    src1_in          = 4'($urandom);
    src2_in          = 4'($urandom);
    sr_in            = 4'($urandom);
  endtask

  // One rising edge: advance the model from the pre-edge inputs, then compare.
  task automatic step(input bit chk);
    @(posedge clk);
    if (!freeze) begin
      if (flush || hazard || !valid_in) exp_vec = '0;
      else exp_vec = in_vec;
      if ((flush || hazard) && exp_cnt < 65535) exp_cnt++;
    end
    #1;
    if (chk) begin
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL entry t=%0t got %h want %h", $time, obs, exp_vec);
      end
      checks++;
      if (bubble_count !== 16'(exp_cnt)) begin
        errors++;
        $display("FAIL bubble_count t=%0t got %0d want %0d", $time, bubble_count, exp_cnt);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_vec = '0;
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    freeze = 0; flush = 0; hazard = 0; valid_in = 1;
    for (int i = 0; i < 3; i++) begin rand_fields(); step(1); end
    // Asynchronous assertion mid-cycle with every input nonzero.
    @(negedge clk);
    #2;
    freeze = 1; flush = 1; hazard = 1; valid_in = 1;
    wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 1; b_in = 1; s_in = 1; imm_in = 1;
    exe_cmd_in = 4'hF; pc_in = 32'hFFFF_FFFF; val_rn_in = 32'h1234_5678; val_rm_in = 32'h9;
    shift_operand_in = 12'hABC; signed_imm_24_in = 24'h123456;
    dest_in = 4'h7; src1_in = 4'h8; src2_in = 4'h9; sr_in = 4'hA;
    rst_n = 1'b0;
    exp_vec = '0;
    exp_cnt = 0;
    #1;
    checks++;
    if (obs !== '0 || bubble_count !== 16'd0) begin
      errors++;
      $display("FAIL async_reset got %h/%0d want 0/0", obs, bubble_count);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== '0 || bubble_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_held got %h/%0d want 0/0", obs, bubble_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    freeze = 0; flush = 0; hazard = 0; valid_in = 1;
    rand_fields();
    dest_in = 4'd3; wb_en_in = 1;
    step(1);
    checks++;
    if (dest !== 4'd3 || wb_en !== 1'b1 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL post_reset got dest=%0d wb_en=%b valid=%b want 3/1/1", dest, wb_en,
               valid_out);
    end
  endtask

  task automatic test_stream();
    freeze = 0; flush = 0; hazard = 0; valid_in = 1;
    for (int i = 1; i <= 4; i++) begin
      rand_fields();
      src1_in = 4'(i);
      step(1);
      checks++;
      if (src1 !== 4'(i) || bubble_count !== 16'd0) begin
        errors++;
        $display("FAIL stream got src1=%0d cnt=%0d want %0d/0", src1, bubble_count, i);
      end
    end
  endtask

  task automatic test_freeze();
    freeze = 0; flush = 0; hazard = 0; valid_in = 1;
    rand_fields();
    pc_in = 32'h100;
    step(1);
    freeze = 1;
    pc_in = 32'h104;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if (pc !== 32'h100) begin
        errors++;
        $display("FAIL freeze_hold got %h want 00000100", pc);
      end
    end
    freeze = 0;
    step(1);
    checks++;
    if (pc !== 32'h104) begin
      errors++;
      $display("FAIL freeze_release got %h want 00000104", pc);
    end
  endtask

  task automatic test_flush_hazard();
    freeze = 0; hazard = 0; valid_in = 1;
    rand_fields();
    flush = 1; wb_en_in = 1; b_in = 1;
    step(1);
    checks++;
    if (valid_out !== 0 || wb_en !== 0 || b !== 0 || bubble_count !== 16'd1) begin
      errors++;
      $display("FAIL flush got v=%b wb=%b b=%b cnt=%0d want 0/0/0/1", valid_out, wb_en, b,
               bubble_count);
    end
    hazard = 1;
    step(1);
    checks++;
    if (bubble_count !== 16'd2) begin
      errors++;
      $display("FAIL flush_and_hazard got %0d want 2", bubble_count);
    end
    // Give the register a live entry, then freeze+flush must leave it alone.
    flush = 0; hazard = 0;
    rand_fields();
    step(1);
    freeze = 1; flush = 1;
    rand_fields();
    step(1);
    checks++;
    if (valid_out !== 1'b1 || bubble_count !== 16'd2) begin
      errors++;
      $display("FAIL freeze_flush got v=%b cnt=%0d want 1/2", valid_out, bubble_count);
    end
    freeze = 0; flush = 0;
  endtask

  task automatic test_idle();
    freeze = 0; flush = 0; hazard = 0; valid_in = 0;
    rand_fields();
    step(1);
    checks++;
    if (valid_out !== 0 || bubble_count !== 16'd2) begin
      errors++;
      $display("FAIL idle got v=%b cnt=%0d want 0/2", valid_out, bubble_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      freeze   = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 5) == 0);
      hazard   = ($urandom_range(0, 5) == 0);
      valid_in = ($urandom_range(0, 5) != 0);
      step(1);
      if (!valid_out) begin
        checks++;
        if ({wb_en, mem_r_en, mem_w_en, b, s} !== 5'b0) begin
          errors++;
          $display("FAIL bubble_ctrl got %b want 00000", {wb_en, mem_r_en, mem_w_en, b, s});
        end
      end
    end
    freeze = 0; flush = 0; hazard = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    freeze = 0; flush = 0; hazard = 1; valid_in = 1;
    for (int i = 1; i <= 65537; i++) begin
      rand_fields();
      step(i >= 65533);
    end
    checks++;
    if (bubble_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturation got %h want ffff", bubble_count);
    end
    hazard = 0;
    step(1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    test_reset();
    test_stream();
    test_freeze();
    test_flush_hazard();
    test_idle();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
